// File: rtl/pp_stage_reg.sv
// Pipeline stage register: a main register plus one skid register, giving a two-deep
// elastic buffer. in_ready is registered, and flush clears both registers to NOP bubbles.
module pp_stage_reg #(
  parameter int unsigned       CTRL_W   = 24,
  parameter int unsigned       FIELD_W  = 8,
  parameter logic [CTRL_W-1:0] NOP_CTRL = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [CTRL_W-1:0]  in_ctrl,
  input  logic [FIELD_W-1:0] in_field,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CTRL_W-1:0]  out_ctrl,
  output logic [FIELD_W-1:0] out_field,
  output logic [1:0]         occupancy,
  output logic [15:0]        stall_cnt
);

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StTwo   = 2'd2
  } state_e;

  state_e             r_state;
  state_e             w_state_nxt;
  logic               r_in_ready;
  logic [CTRL_W-1:0]  r_main_ctrl;
  logic [CTRL_W-1:0]  w_main_ctrl_nxt;
  logic [FIELD_W-1:0] r_main_field;
  logic [FIELD_W-1:0] w_main_field_nxt;
  logic [CTRL_W-1:0]  r_skid_ctrl;
  logic [CTRL_W-1:0]  w_skid_ctrl_nxt;
  logic [FIELD_W-1:0] r_skid_field;
  logic [FIELD_W-1:0] w_skid_field_nxt;
  logic [15:0]        r_stall_cnt;
  logic [15:0]        w_stall_cnt_nxt;
  logic               w_out_valid;
  logic               w_accept;
  logic               w_consume;

  assign w_out_valid = (r_state != StEmpty);
  assign w_accept    = in_valid & r_in_ready;
  assign w_consume   = w_out_valid & out_ready;

  always_comb begin
    w_state_nxt      = r_state;
    w_main_ctrl_nxt  = r_main_ctrl;
    w_main_field_nxt = r_main_field;
    w_skid_ctrl_nxt  = r_skid_ctrl;
    w_skid_field_nxt = r_skid_field;

    if (flush) begin
      w_state_nxt      = StEmpty;
      w_main_ctrl_nxt  = NOP_CTRL;
      w_main_field_nxt = '0;
      w_skid_ctrl_nxt  = NOP_CTRL;
      w_skid_field_nxt = '0;
    end else begin
      unique case (r_state)
        StEmpty: begin
          if (w_accept) begin
            w_state_nxt      = StOne;
            w_main_ctrl_nxt  = in_ctrl;
            w_main_field_nxt = in_field;
          end
        end
        StOne: begin
          if (w_accept && w_consume) begin
            w_main_ctrl_nxt  = in_ctrl;
            w_main_field_nxt = in_field;
          end else if (w_accept) begin
            w_state_nxt      = StTwo;
            w_skid_ctrl_nxt  = in_ctrl;
            w_skid_field_nxt = in_field;
          end else if (w_consume) begin
            // Going empty: main reverts to a bubble so no downstream enable fires.
            w_state_nxt      = StEmpty;
            w_main_ctrl_nxt  = NOP_CTRL;
            w_main_field_nxt = '0;
          end
        end
        StTwo: begin
          if (w_consume) begin
            w_state_nxt      = StOne;
            w_main_ctrl_nxt  = r_skid_ctrl;
            w_main_field_nxt = r_skid_field;
            w_skid_ctrl_nxt  = NOP_CTRL;
            w_skid_field_nxt = '0;
          end
        end
        default: begin
          w_state_nxt      = StEmpty;
          w_main_ctrl_nxt  = NOP_CTRL;
          w_main_field_nxt = '0;
          w_skid_ctrl_nxt  = NOP_CTRL;
          w_skid_field_nxt = '0;
        end
      endcase
    end
  end

  always_comb begin
    w_stall_cnt_nxt = r_stall_cnt;
    if (w_out_valid && !out_ready && (r_stall_cnt != 16'hFFFF)) begin
      w_stall_cnt_nxt = r_stall_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= StEmpty;
      r_in_ready   <= 1'b1;
      r_main_ctrl  <= NOP_CTRL;
      r_main_field <= '0;
      r_skid_ctrl  <= NOP_CTRL;
      r_skid_field <= '0;
      r_stall_cnt  <= '0;
    end else begin
      r_state      <= w_state_nxt;
      // Registered ready, so there is no combinational path from out_ready.
      r_in_ready   <= (w_state_nxt != StTwo);
      r_main_ctrl  <= w_main_ctrl_nxt;
      r_main_field <= w_main_field_nxt;
      r_skid_ctrl  <= w_skid_ctrl_nxt;
      r_skid_field <= w_skid_field_nxt;
      r_stall_cnt  <= w_stall_cnt_nxt;
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = w_out_valid;
  assign out_ctrl  = r_main_ctrl;
  assign out_field = r_main_field;
  assign occupancy = r_state;
  assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_pp_stage_reg.sv
// Scoreboard bench for pp_stage_reg: the stimulus side pushes accepted words into a queue,
// and the negedge monitor checks outputs against that queue and a saturating stall model.
module tb_pp_stage_reg;

  localparam int unsigned       CTRL_W  = 24;
  localparam int unsigned       FIELD_W = 8;
  localparam logic [CTRL_W-1:0] NOP     = 24'hA55A01;

  logic               clk;
  logic               reset;
  logic               in_valid;
  logic               in_ready;
  logic [CTRL_W-1:0]  in_ctrl;
  logic [FIELD_W-1:0] in_field;
  logic               flush;
  logic               out_valid;
  logic               out_ready;
  logic [CTRL_W-1:0]  out_ctrl;
  logic [FIELD_W-1:0] out_field;
  logic [1:0]         occupancy;
  logic [15:0]        stall_cnt;

  pp_stage_reg #(
    .CTRL_W  (CTRL_W),
    .FIELD_W (FIELD_W),
    .NOP_CTRL(NOP)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_ctrl  (in_ctrl),
    .in_field (in_field),
    .flush    (flush),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_ctrl (out_ctrl),
    .out_field(out_field),
    .occupancy(occupancy),
    .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Words currently held by the stage, oldest first, plus the expected stall count.
  logic [31:0] exp_q[$];
  int          m_cnt   = 0;
  logic [15:0] m_stall = '0;
  bit          mon_en  = 1'b0;
  int          n_cmp   = 0;
  int          n_err   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      chk("occupancy", 64'(occupancy), 64'(m_cnt));
      chk("in_ready", 64'(in_ready), 64'(m_cnt < 2));
      chk("out_valid", 64'(out_valid), 64'(m_cnt != 0));
      chk("stall_cnt", 64'(stall_cnt), 64'(m_stall));
      if (m_cnt == 0) begin
        chk("bubble_ctrl", 64'(out_ctrl), 64'(NOP));
        chk("bubble_field", 64'(out_field), 64'd0);
      end else if (exp_q.size() > 0) begin
        chk("out_word", 64'({out_ctrl, out_field}), 64'(exp_q[0]));
      end
      if (reset) begin
        exp_q.delete();
        m_stall = '0;
      end else begin
        if (m_cnt > 0 && !out_ready && m_stall != 16'hFFFF) m_stall = m_stall + 16'd1;
        if (flush) exp_q.delete();
        else if (m_cnt > 0 && out_ready) void'(exp_q.pop_front());
      end
      m_cnt = exp_q.size();
    end
  end

  task automatic drive(input bit v, input logic [31:0] w, input bit rdy, input bit fl,
                       input bit rs);
    @(posedge clk);
    #1;
    in_valid  = v;
    {in_ctrl, in_field} = w;
    out_ready = rdy;
    flush     = fl;
    reset     = rs;
    if (v && m_cnt < 2 && !fl && !rs) exp_q.push_back(w);
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) drive(1'b0, 32'h0, rdy, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_ctrl = '0; in_field = '0;
    flush = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    mon_en = 1'b1;
    idle(3, 1'b0);

    // Back-to-back flow with a ready consumer.
    drive(1'b1, 32'h1111_1101, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 32'h2222_2202, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 32'h3333_3303, 1'b1, 1'b0, 1'b0);
    idle(2, 1'b1);

    // Fill under backpressure, then drain.
    drive(1'b1, 32'h4444_4404, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'h5555_5505, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'h6666_6606, 1'b0, 1'b0, 1'b0);
    idle(3, 1'b0);
    idle(3, 1'b1);

    // Flush while full with a word offered.
    drive(1'b1, 32'h7777_7707, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'h8888_8808, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'h9999_9909, 1'b0, 1'b1, 1'b0);
    idle(2, 1'b1);

    // Reset and flush together while full.
    drive(1'b1, 32'hAAAA_AA0A, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'hBBBB_BB0B, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'hCCCC_CC0C, 1'b0, 1'b1, 1'b1);
    idle(2, 1'b0);

    for (int i = 0; i < 3000; i++) begin
      drive(($urandom % 4) != 0, $urandom(), ($urandom % 3) != 0,
            ($urandom % 25) == 0, ($urandom % 100) == 0);
    end
    idle(3, 1'b1);

    // Long hold to saturate the stall counter.
    drive(1'b1, 32'hDDDD_DD0D, 1'b0, 1'b0, 1'b0);
    idle(70000, 1'b0);
    @(negedge clk);
    #1;
    chk("stall_saturated", 64'(stall_cnt), 64'hFFFF);
    idle(3, 1'b1);

    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pp_stage_reg.md
PP_STAGE_REG -- requirements
Module: pp_stage_reg

Interface
REQ-001 Parameter CTRL_W, default 24: width of the decoded control word (branch, acc/op2 mux selects, ALU opcode, RAM/IO/peripheral enables).
REQ-002 Parameter FIELD_W, default 8: width of the instruction operand field.
REQ-003 Parameter NOP_CTRL, default 0 (CTRL_W bits): control word driven whenever the stage holds no valid instruction.
REQ-004 Port clk  in  1  single clock; all state changes on its rising edge.
REQ-005 Port reset  in  1  synchronous, active-high reset.
REQ-006 Port in_valid  in  1  upstream offers a word this cycle.
REQ-007 Port in_ready  out  1  stage can accept a word this cycle.
REQ-008 Port in_ctrl  in  CTRL_W  incoming control word.
REQ-009 Port in_field  in  FIELD_W  incoming operand field.
REQ-010 Port flush  in  1  discard all held and offered words (branch taken).
REQ-011 Port out_valid  out  1  out_ctrl/out_field hold a valid word.
REQ-012 Port out_ready  in  1  downstream consumes the output word this cycle.
REQ-013 Port out_ctrl  out  CTRL_W  registered control word.
REQ-014 Port out_field  out  FIELD_W  registered operand field.
REQ-015 Port occupancy  out  2  words held: 0, 1 or 2.
REQ-016 Port stall_cnt  out  16  saturating count of backpressure cycles.

Function
REQ-017 Storage SHALL be a main register (drives outputs) plus one skid register; states EMPTY (0), ONE (1), TWO (2); occupancy SHALL equal the state encoding.
REQ-018 in_ready SHALL be a registered signal, 1 in EMPTY and ONE, 0 in TWO; it SHALL NOT depend combinationally on out_ready.
REQ-019 Accept = in_valid & in_ready; consume = out_valid & out_ready.
REQ-020 EMPTY: accept -> ONE, main loaded; latency from accept to out_valid is exactly 1 cycle.
REQ-021 ONE: accept & consume -> ONE, main reloaded from input; accept & !consume -> TWO, skid loaded; !accept & consume -> EMPTY; neither -> hold.
REQ-022 TWO: consume -> ONE, main loaded from skid, skid cleared; !consume -> hold.
REQ-023 Ordering SHALL be strict FIFO; no word duplicated or dropped except by flush or reset.
REQ-024 out_valid = 1 in ONE and TWO, 0 in EMPTY.
REQ-025 When out_valid = 0, out_ctrl SHALL equal NOP_CTRL and out_field SHALL equal 0, so that no downstream enable fires on a bubble.
REQ-026 While held (out_valid = 1, out_ready = 0), out_ctrl and out_field SHALL remain stable.
REQ-027 Flush SHALL take priority over every transition: next state EMPTY, main and skid loaded with NOP_CTRL/0, in_ready = 1 next cycle; a word offered in the flush cycle is discarded even if in_ready = 1.
REQ-028 stall_cnt SHALL increment by 1 each cycle with out_valid = 1 and out_ready = 0, SHALL saturate at 16'hFFFF, and is unaffected by flush.

Reset
REQ-029 Reset SHALL dominate flush and all handshakes, including mid-operation in any state.
REQ-030 On the edge with reset = 1: state EMPTY, occupancy 0, out_valid 0, in_ready 1, out_ctrl NOP_CTRL, out_field 0, skid NOP_CTRL/0, stall_cnt 0.

Verification
REQ-031 Reset release, no traffic -> out_valid 0, in_ready 1, occupancy 0, out_ctrl = NOP_CTRL, stall_cnt 0.
REQ-032 out_ready = 1, A, B, C offered on consecutive cycles -> each appears one cycle later on consecutive cycles, in_ready stays 1, occupancy stays 1.
REQ-033 out_ready = 0, offer A then B -> occupancy 2, in_ready 0, out shows A; raise out_ready -> A consumed, then B, in_ready back to 1 the cycle after A is consumed; stall_cnt = number of held cycles.
REQ-034 Occupancy 2 with in_valid = 1 and flush = 1 -> next cycle occupancy 0, out_valid 0, out_ctrl = NOP_CTRL, offered word never appears.
REQ-035 Hold out_ready = 0 with a valid word for 70000 cycles -> stall_cnt stops at 16'hFFFF.
REQ-036 Reset and flush asserted together at occupancy 2 -> full reset values per REQ-030 next cycle, stall_cnt 0.
